mips_multicycle_ctrl: RTL
=========================

Name: mips_multicycle_ctrl

Overview:
- Multi-cycle control sequencer for the Lab 4 ALU-only MIPS datapath (register file, ALU, sign/zero extender, PC register).
- Fetches an instruction word over a req/ack handshake, decodes the R-type (add/sub/and/or/nor/xor) and I-type (addi/andi/ori/xori) subset, then drives the ALU and register-file controls over fixed EXEC/WB cycles.
- Steps the PC and counts retired instructions.
- Flags unsupported instructions with a sticky exception and stops.

Parameters:
- CNT_W, 16, width of retired-instruction counter
- OPCODE_W, 6, opcode/funct field width (fixed by ISA; not to be overridden)

Ports:
- clock  input  1  system clock, rising edge
- reset  input  1  asynchronous, active-high reset
- inst  input  32  instruction word from instruction memory; sampled only when imem_req && imem_ack
- imem_ack  input  1  instruction memory: inst valid this cycle
- stall  input  1  hold in EXEC while high
- imem_req  output  1  fetch request
- alu_op  output  3  ALU operation select
- alu_src2  output  2  ALU B-source select: 00 = rt, 01 = sign-extended imm16, 10 = zero-extended imm16
- rd_src  output  1  destination select: 0 = rd field, 1 = rt field
- writeenable  output  1  register-file write strobe
- pc_en  output  1  PC += 4 strobe
- except  output  1  sticky unsupported-instruction flag
- retired  output  CNT_W  count of completed instructions

Behaviour:
- Clock and reset: one clock; reset is asynchronous and active-high, ports named clock and reset.
- Reset values: state FETCH, IR 0, alu_op 0, alu_src2 00, rd_src 0, writeenable 0, pc_en 0, except 0, retired 0.
- States: FETCH, DECODE, EXEC, WB, EXCEPT. All outputs are Moore/registered; none depends combinationally on inst.
- FETCH:
  - imem_req = 1.
  - On imem_ack: latch inst into IR, go to DECODE.
  - Otherwise stay; wait is unbounded.
- DECODE (1 cycle): decode IR[31:26] and IR[5:0], then register alu_op/alu_src2/rd_src.
  - opcode 0x00:
    - funct 0x20 add: alu_op 010
    - funct 0x22 sub: alu_op 011
    - funct 0x24 and: alu_op 100
    - funct 0x25 or: alu_op 101
    - funct 0x27 nor: alu_op 110
    - funct 0x26 xor: alu_op 111
    - All R-type: alu_src2 00, rd_src 0.
  - Immediates, all with rd_src 1:
    - 0x08 addi: alu_op 010, alu_src2 01
    - 0x0c andi: alu_op 100, alu_src2 10
    - 0x0d ori: alu_op 101, alu_src2 10
    - 0x0e xori: alu_op 111, alu_src2 10
  - Any other opcode, or opcode 0 with any other funct: go to EXCEPT. Control outputs are not updated.
  - Supported instruction: go to EXEC.
- EXEC:
  - Controls are stable.
  - stall = 1: remain in EXEC.
  - stall = 0: go to WB.
- WB (exactly 1 cycle):
  - writeenable = 1 and pc_en = 1.
  - retired increments by 1 on leaving WB; wraps modulo 2^CNT_W with no flag.
  - Next state FETCH.
- EXCEPT (terminal):
  - except = 1 and held.
  - imem_req, writeenable and pc_en are 0.
  - Only reset exits.
- Controls: alu_op, alu_src2 and rd_src hold their last decoded value outside EXEC/WB; consumers ignore them there.
- Strobes: writeenable and pc_en are 1 only in WB, always together, exactly one cycle per retired instruction.
- Minimum latency: ack in cycle N → DECODE N+1 → EXEC N+2 → WB N+3 → imem_req again N+4 (4 cycles/instruction without stalls).
- Reset mid-operation: any state returns to FETCH immediately (asynchronously).
  - A WB in progress is aborted: writeenable drops, retired is not incremented.
- Ack arriving with reset: ignored; IR stays 0.
- imem_ack outside FETCH: ignored.

Test Plan:
- Reset, then ack add (0x00432020) at cycle 2 → alu_op 010 / alu_src2 00 / rd_src 0 from cycle 4; writeenable = pc_en = 1 only in cycle 5; retired = 1; imem_req high cycle 6.
- Back-to-back sub, and, or, nor, xor, addi, andi, ori, xori with immediate acks → alu_op 011,100,101,110,111,010,100,101,111; alu_src2 00×5, 01, 10×3; rd_src 0×5 then 1×4; retired = 10 after 40 cycles.
- Hold stall = 1 for 3 cycles in EXEC of an ori → WB delayed 3 cycles; exactly one writeenable pulse; retired increments once.
- Fetch opcode 0x23 (lw), then funct 0x21 (addu) after reset → except = 1 from the cycle after DECODE and held; writeenable/pc_en/imem_req stay 0 for 20 cycles; retired unchanged; reset clears except.
- Assert reset asynchronously (mid-cycle) during WB → writeenable falls without a clock edge; retired not incremented; FETCH with imem_req = 1 after release.
- Preload CNT_W = 4, retire 17 instructions → retired = 1 (wrap), no other side effect.

Source files
------------

// File: rtl/mips_multicycle_ctrl.sv
// mips_multicycle_ctrl: multi-cycle FETCH/DECODE/EXEC/WB sequencer for the ALU-only MIPS datapath
// Ports:
//   clock, reset         rising-edge clock, asynchronous active-high reset
//   inst, imem_ack       instruction word and its valid strobe (taken in FETCH only)
//   imem_req             fetch request, high in FETCH
//   stall                holds the sequencer in EXEC
//   alu_op, alu_src2,    registered ALU / register-file controls, loaded in DECODE
//   rd_src
//   writeenable, pc_en   one-cycle strobes in WB
//   except               sticky unsupported-instruction flag
//   retired              count of completed instructions, wraps silently
module mips_multicycle_ctrl #(
    parameter int CNT_W    = 16,
    parameter int OPCODE_W = 6
) (
    input  logic             clock,
    input  logic             reset,
    input  logic [31:0]      inst,
    input  logic             imem_ack,
    input  logic             stall,
    output logic             imem_req,
    output logic [2:0]       alu_op,
    output logic [1:0]       alu_src2,
    output logic             rd_src,
    output logic             writeenable,
    output logic             pc_en,
    output logic             except,
    output logic [CNT_W-1:0] retired
);
    typedef enum logic [2:0] {FETCH, DECODE, EXEC, WB, EXCEPT} state_t;
    state_t state, state_nx;
    // only the opcode and funct fields of IR are ever consulted
    logic [OPCODE_W-1:0] opcode, funct;
    logic       valid;
    logic [2:0] dec_op;
    logic [1:0] dec_src2;
    logic       dec_rd;
    always_comb begin
        valid    = 1'b1;
        dec_op   = 3'b000;
        dec_src2 = 2'b00;
        dec_rd   = 1'b0;
        case (opcode)
            6'h00: case (funct)
                6'h20:   dec_op = 3'b010;
                6'h22:   dec_op = 3'b011;
                6'h24:   dec_op = 3'b100;
                6'h25:   dec_op = 3'b101;
                6'h27:   dec_op = 3'b110;
                6'h26:   dec_op = 3'b111;
                default: valid  = 1'b0;
            endcase
            6'h08:   {dec_op, dec_src2, dec_rd} = {3'b010, 2'b01, 1'b1};
            6'h0c:   {dec_op, dec_src2, dec_rd} = {3'b100, 2'b10, 1'b1};
            6'h0d:   {dec_op, dec_src2, dec_rd} = {3'b101, 2'b10, 1'b1};
            6'h0e:   {dec_op, dec_src2, dec_rd} = {3'b111, 2'b10, 1'b1};
            default: valid = 1'b0;
        endcase
    end
    always_comb begin
        state_nx = state;
        case (state)
            FETCH:   state_nx = imem_ack ? DECODE : FETCH;
            DECODE:  state_nx = valid ? EXEC : EXCEPT;
            EXEC:    state_nx = stall ? EXEC : WB;
            WB:      state_nx = FETCH;
            default: state_nx = state;
        endcase
    end
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state    <= FETCH;
            opcode   <= '0;
            funct    <= '0;
            alu_op   <= 3'b000;
            alu_src2 <= 2'b00;
            rd_src   <= 1'b0;
            retired  <= '0;
        end else begin
            state <= state_nx;
            if (state == FETCH && imem_ack) begin
                opcode <= inst[31:32-OPCODE_W];
                funct  <= inst[OPCODE_W-1:0];
            end
            // an unsupported instruction leaves the previous controls in place
            if (state == DECODE && valid) {alu_op, alu_src2, rd_src} <= {dec_op, dec_src2, dec_rd};
            if (state == WB) retired <= retired + 1'b1;
        end
    end
    // strobes come straight from the state register so an async reset drops them at once
    assign imem_req    = state == FETCH;
    assign writeenable = state == WB;
    assign pc_en       = state == WB;
    assign except      = state == EXCEPT;
endmodule
